// File: rtl/shift_sequencer.sv
// Purpose : multi-cycle 32-bit barrel shifter (SRL / SLL / SRA) that applies
//           one power-of-two stage per clock (16, 8, 4, 2, 1).
// Latency : 5 cycles from accepted start to the done pulse; with ZERO_SKIP=1
//           a zero shift amount completes in 1 cycle.
// Backpressure: none; start is only sampled while idle (busy=0) and is
//           silently ignored otherwise, including during the done cycle.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset
//   start  in   1   begin a shift (sampled only in IDLE)
//   op     in   2   00 SRL, 01 SLL, 10 SRA, 11 treated as SRL
//   shamt  in   5   shift amount 0-31
//   din    in  32   operand
//   busy   out  1   state != IDLE
//   done   out  1   one-cycle pulse, dout valid in that cycle
//   dout   out 32   result register, held until the next result or reset

module shift_sequencer #(
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] data_q;     // operand being shifted, one stage per cycle
    logic [1:0]  op_q;
    logic [4:0]  shamt_q;
    logic        sign_q;     // operand bit 31 at acceptance, SRA fill value
    logic [2:0]  k_q;        // current stage index, 4 down to 0
    logic [31:0] dout_q;

    logic        accept;
    logic        zero_skip;
    logic [4:0]  stage_amt;
    logic [31:0] srl_val;
    logic [31:0] sll_val;
    logic [31:0] sra_fill;
    logic [31:0] stage_out;

    assign accept    = (state_q == S_IDLE) && start;
    assign zero_skip = ZERO_SKIP && (shamt == 5'd0);

    // ------------------------------------------------------------------
    // One shift stage: distance is 2^k when bit k of the amount is set,
    // otherwise the data passes through. Bits shifted past either end are
    // dropped, so the five stages compose to a single 0-31 shift.
    // ------------------------------------------------------------------
    always_comb begin
        stage_amt = 5'd0;
        if (shamt_q[k_q]) begin
            stage_amt = 5'd1 << k_q;
        end
    end

    assign srl_val  = data_q >> stage_amt;
    assign sll_val  = data_q << stage_amt;
    // Vacated high bits are filled from the latched sign, not from the
    // partially shifted data, so the fill is fixed for the whole operation.
    assign sra_fill = (op_q == OP_SRA && sign_q) ? ~(32'hFFFF_FFFF >> stage_amt)
                                                 : 32'h0000_0000;

    always_comb begin
        stage_out = srl_val | sra_fill;
        if (op_q == OP_SLL) begin
            stage_out = sll_val;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (k_q == 3'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 32'h0000_0000;
            op_q    <= OP_SRL;
            shamt_q <= 5'd0;
            sign_q  <= 1'b0;
            k_q     <= 3'd0;
            dout_q  <= 32'h0000_0000;
        end else begin
            if (accept) begin
                data_q  <= din;
                // Reserved encoding is folded to SRL once, here, so the
                // stage logic only ever sees the three real operations.
                op_q    <= (op == OP_RSV) ? OP_SRL : op;
                shamt_q <= shamt;
                sign_q  <= din[31];
                // A skipped zero shift enters at the last stage; with a
                // zero amount that stage is a pass-through, so DONE is
                // reached one cycle after acceptance with dout = din.
                k_q     <= zero_skip ? 3'd0 : 3'd4;
            end else if (state_q == S_SHIFT) begin
                data_q <= stage_out;
                if (k_q != 3'd0) begin
                    k_q <= k_q - 3'd1;
                end else begin
                    dout_q <= stage_out;
                end
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign dout = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic        busy0, done0, busy1, done1;
    logic [31:0] dout0, dout1;

    always #5 clk = ~clk;

    // Instance 0: full five-stage path always; instance 1: zero-skip enabled.
    shift_sequencer #(.ZERO_SKIP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt), .din(din),
        .busy(busy0), .done(done0), .dout(dout0)
    );

    shift_sequencer #(.ZERO_SKIP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .shamt(shamt), .din(din),
        .busy(busy1), .done(done1), .dout(dout1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an operation is a countdown of busy cycles; the
    // result is the plain shift of the operand.  m_r = cycles of busy left
    // (0 = idle, 1 = the done cycle).
    // ------------------------------------------------------------------
    int          m_r[2]    = '{0, 0};
    logic [31:0] m_dout[2] = '{32'h0, 32'h0};
    logic [31:0] m_res[2];

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s,
                                              input logic [31:0] d);
        case (o)
            2'b01:   return d << s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d >> s;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_r[i]    = 0;
                m_dout[i] = 32'h0;
            end else if (m_r[i] == 0) begin
                if (start) begin
                    m_res[i] = ref_shift(op, shamt, din);
                    m_r[i]   = (i == 1 && shamt == 5'd0) ? 2 : 6;
                end
            end else begin
                m_r[i]--;
                if (m_r[i] == 1) m_dout[i] = m_res[i];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy0", {31'b0, busy0}, {31'b0, m_r[0] != 0});
            chk("done0", {31'b0, done0}, {31'b0, m_r[0] == 1});
            chk("dout0", dout0, m_dout[0]);
            chk("busy1", {31'b0, busy1}, {31'b0, m_r[1] != 0});
            chk("done1", {31'b0, done1}, {31'b0, m_r[1] == 1});
            chk("dout1", dout1, m_dout[1]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        op    = 2'($urandom);
        shamt = 5'($urandom);
        din   = $urandom;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while ((busy0 || busy1) && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("idle_timeout", {31'b0, busy0 | busy1}, 32'h0);
    endtask

    // Issue one op, check latency and result on instance 0 against literals.
    task automatic do_op(input string name, input logic [1:0] o, input logic [4:0] s,
                         input logic [31:0] d, input logic [31:0] exp);
        int cnt = 0;
        start = 1'b1; op = o; shamt = s; din = d;
        tick();
        start = 1'b0;
        scramble();
        while (!done0 && cnt < 12) begin
            tick();
            cnt++;
        end
        chk({name, "_lat"}, 32'(cnt), 32'd5);
        chk({name, "_dout"}, dout0, exp);
        tick();
        chk({name, "_hold"}, dout0, exp);
        wait_idle();
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; din = 32'h0;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_busy0", {31'b0, busy0}, 32'h0);
        chk("rst_done0", {31'b0, done0}, 32'h0);
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        rst = 1'b0;
        scramble();
        tick();

        do_op("srl31",  2'b00, 5'd31, 32'h8000_0000, 32'h0000_0001);
        do_op("sll16",  2'b01, 5'd16, 32'h0000_0001, 32'h0001_0000);
        do_op("sll5",   2'b01, 5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFE0);
        do_op("sra4",   2'b10, 5'd4,  32'h8000_0000, 32'hF800_0000);
        do_op("rsv4",   2'b11, 5'd4,  32'h8000_0000, 32'h0800_0000);
        do_op("sra31",  2'b10, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF);
        do_op("sra_pos",2'b10, 5'd3,  32'h7000_0000, 32'h0E00_0000);

        // Zero shift: instance 1 finishes after 1 cycle, instance 0 after 5.
        start = 1'b1; op = 2'b00; shamt = 5'd0; din = 32'h1234_5678;
        tick();
        start = 1'b0;
        scramble();
        cnt = 0;
        while (!done0 && cnt < 12) begin
            tick();
            cnt++;
            if (cnt == 1) begin
                chk("zs_done1", {31'b0, done1}, 32'h1);
                chk("zs_dout1", dout1, 32'h1234_5678);
                chk("zs_done0_early", {31'b0, done0}, 32'h0);
            end
        end
        chk("zs_lat0", 32'(cnt), 32'd5);
        chk("zs_dout0", dout0, 32'h1234_5678);
        tick();
        wait_idle();

        // Start held high through the whole operation with a new operand.
        start = 1'b1; op = 2'b00; shamt = 5'd4; din = 32'h0000_0F00;
        tick();
        op = 2'b01; shamt = 5'd8; din = 32'hDEAD_BEEF;
        cnt = 0;
        while (!done0 && cnt < 12) begin
            tick();
            cnt++;
        end
        chk("intf_lat", 32'(cnt), 32'd5);
        chk("intf_dout", dout0, 32'h0000_00F0);
        tick();
        chk("intf_idle_busy", {31'b0, busy0}, 32'h0);
        chk("intf_idle_dout", dout0, 32'h0000_00F0);
        tick();
        chk("intf_reaccept", {31'b0, busy0}, 32'h1);
        start = 1'b0;
        scramble();
        wait_idle();
        chk("intf_second", dout0, 32'hADBE_EF00);

        // Reset during the third SHIFT cycle.
        start = 1'b1; op = 2'b00; shamt = 5'd8; din = 32'hFFFF_0100;
        tick();
        start = 1'b0;
        scramble();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'b0, busy0}, 32'h0);
        chk("mid_rst_done", {31'b0, done0}, 32'h0);
        chk("mid_rst_dout", dout0, 32'h0);
        // Reset wins over a simultaneous start.
        start = 1'b1;
        tick();
        chk("rst_prio_busy", {31'b0, busy0}, 32'h0);
        rst = 1'b0; start = 1'b0;
        tick();
        do_op("post_rst", 2'b00, 5'd8, 32'h0000_0100, 32'h0000_0001);

        // Random operations, checked cycle by cycle against the model.
        for (int i = 0; i < 24; i++) begin
            start = 1'b1;
            op    = 2'($urandom);
            shamt = (i % 4 == 0) ? 5'd0 : 5'($urandom);
            din   = $urandom;
            tick();
            start = 1'b0;
            scramble();
            tick();
            wait_idle();
            repeat (int'($urandom_range(0, 2))) tick();
        end

        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
